// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, fetch FSM states and default reset PC.
package mips_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Next-PC selection: JR > J/JAL > taken branch > sequential, all modulo 2^32.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] jr_target,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        JumpSel,
    input  logic        branch_taken,
    output logic [31:0] target
);

    logic [31:0] jump_addr;
    logic [31:0] branch_addr;
    logic        unused_opcode;

    // Opcode bits are decoded by control; only the target/imm fields matter here.
    assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

    assign jump_addr   = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    assign branch_addr = pc_plus4 + {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};

    always_comb begin
        target = pc_plus4;
        if (Jump && JumpSel)
            target = jr_target;
        else if (Jump)
            target = jump_addr;
        else if (Branch && branch_taken)
            target = branch_addr;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, imem req/ack FSM and decoded-field presentation.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        JumpSel,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic        addr_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [31:0]  target;

    next_pc_sel u_next_pc_sel (
        .pc_plus4     (pc_plus4),
        .instr        (instr_q),
        .jr_target    (jr_target),
        .Jump         (Jump),
        .Branch       (Branch),
        .JumpSel      (JumpSel),
        .branch_taken (branch_taken),
        .target       (target)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic addr_err_q, addr_err_d;
    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        addr_err_d = addr_err_q;
`endif
        case (state_q)
            FETCH: begin
                // The first cycle out of reset only raises the request; acks are
                // honoured only against an outstanding request.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (target[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = target;
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
`else
                    pc_d    = target & ~32'h3;
                    req_d   = 1'b1;
                    state_d = FETCH;
`endif
                end
            end
            HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            addr_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            addr_err_q <= addr_err_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign rs          = instr_q[RS_MSB:RS_LSB];
    assign rt          = instr_q[RT_MSB:RT_LSB];
    assign rd          = instr_q[RD_MSB:RD_LSB];
    assign imm         = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected fetch addresses, per-feature tasks.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] pc, pc_plus4;
    logic        Jump = 1'b0, Branch = 1'b0, JumpSel = 1'b0, branch_taken = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        addr_err;

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_word, cur_pc;

    localparam logic [31:0] W_ADD = 32'h012A_4020;
    localparam logic [31:0] W_ORI = 32'h3508_00FF;
    localparam logic [31:0] W_LW  = 32'h8D09_0004;
    localparam logic [31:0] W_J   = 32'h0810_0004;
    localparam logic [31:0] W_JAL = 32'h0C10_0040;
    localparam logic [31:0] W_JR  = 32'h03E0_0008;
    localparam logic [31:0] W_BNE = 32'h1509_FFFE;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .pc(pc), .pc_plus4(pc_plus4),
        .Jump(Jump), .Branch(Branch), .JumpSel(JumpSel), .branch_taken(branch_taken),
        .jr_target(jr_target), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

    // Wait for a request, check its address against the scoreboard, answer after lat cycles.
    task automatic fetch_word(input logic [31:0] word, input int lat, output int waited);
        logic [31:0] exp_a;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL req_timeout act=%b exp=1", imem_req);
            return;
        end
        exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (imem_addr !== exp_a) begin
            n_err++;
            $display("FAIL imem_addr act=%h exp=%h", imem_addr, exp_a);
        end
        n_checks++;
        if (pc !== exp_a) begin
            n_err++;
            $display("FAIL pc_at_fetch act=%h exp=%h", pc, exp_a);
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_a || instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL wait_stable act=req%b/%h/v%b exp=req1/%h/v0",
                         imem_req, imem_addr, instr_valid, exp_a);
            end
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        n_checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word) begin
            n_err++;
            $display("FAIL present act=v%b req%b %h exp=v1 req0 %h", instr_valid, imem_req, instr, word);
        end
        n_checks++;
        if ({opcode, rs, rt, rd, imm, funct} !==
            {word[31:26], word[25:21], word[20:16], word[15:11], word[15:0], word[5:0]}) begin
            n_err++;
            $display("FAIL fields act=%h/%h/%h/%h/%h/%h word=%h", opcode, rs, rt, rd, imm, funct, word);
        end
        cur_word = word;
        cur_pc = exp_a;
    endtask

    // Hold the presented instruction for `hold` cycles (with stray acks), then consume it.
    task automatic consume(input logic j, input logic js, input logic b, input logic bt,
                           input logic [31:0] jr, input logic [31:0] exp_next, input int hold);
        for (int i = 0; i < hold; i++) begin
            imem_ack = 1'b1;
            imem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== cur_word || pc !== cur_pc || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable act=v%b %h %h req%b exp=v1 %h %h req0",
                         instr_valid, instr, pc, imem_req, cur_word, cur_pc);
            end
        end
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        Jump = j; JumpSel = js; Branch = b; branch_taken = bt; jr_target = jr;
        instr_ready = 1'b1;
        exp_q.push_back(exp_next);
        @(negedge clk);
        instr_ready = 1'b0;
        Jump = 1'b0; JumpSel = 1'b0; Branch = 1'b0; branch_taken = 1'b0; jr_target = 32'h0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_next) begin
            n_err++;
            $display("FAIL consume act=v%b req%b %h exp=v0 req1 %h", instr_valid, imem_req, imem_addr, exp_next);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state act=req%b v%b pc=%h i=%h e%b exp=req0 v0 pc=0 i=0 e0",
                     imem_req, instr_valid, pc, instr, addr_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL first_req act=req%b %h exp=req1 00000000", imem_req, imem_addr);
        end
        exp_q.push_back(32'h0);
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        int waited;
        words[0] = W_ADD; words[1] = W_ORI; words[2] = W_LW;
        for (int i = 0; i < 3; i++) begin
            fetch_word(words[i], 0, waited);
            n_checks++;
            if (waited != 0) begin
                n_err++;
                $display("FAIL seq_cadence act=%0d exp=0", waited);
            end
            consume(0, 0, 0, 0, 32'h0, 32'(4 * (i + 1)), 0);
        end
    endtask

    task automatic test_backpressure();
        int waited;
        fetch_word(W_J, 3, waited);
        consume(1, 0, 0, 0, 32'h0, 32'h0040_0010, 4);
    endtask

    task automatic test_jump();
        int waited;
        fetch_word(W_JAL, 0, waited);
        n_checks++;
        if (pc !== 32'h0040_0010 || pc_plus4 !== 32'h0040_0014) begin
            n_err++;
            $display("FAIL jal_link act=%h/%h exp=00400010/00400014", pc, pc_plus4);
        end
        consume(1, 0, 0, 0, 32'h0, 32'h0040_0100, 0);
        // JR with a taken branch asserted at the same time: jump has priority.
        fetch_word(W_JR, 1, waited);
        consume(1, 1, 1, 1, 32'h0000_0100, 32'h0000_0100, 0);
    endtask

    task automatic test_branch();
        int waited;
        fetch_word(W_BNE, 0, waited);
        consume(0, 0, 1, 1, 32'h0, 32'h0000_00FC, 0);
        fetch_word(W_JR, 0, waited);
        consume(1, 1, 0, 0, 32'h0000_0100, 32'h0000_0100, 0);
        fetch_word(W_BNE, 0, waited);
        consume(0, 0, 1, 0, 32'h0, 32'h0000_0104, 0);
    endtask

    task automatic test_jr_misalign();
        int waited;
        fetch_word(W_JR, 0, waited);
`ifdef FETCH_MISALIGN_TRAP_EN
        Jump = 1'b1; JumpSel = 1'b1; jr_target = 32'h0000_2002;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0; Jump = 1'b0; JumpSel = 1'b0; jr_target = 32'h0;
        repeat (3) begin
            n_checks++;
            if (addr_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0000_0104) begin
                n_err++;
                $display("FAIL trap_halt act=e%b req%b v%b pc=%h exp=e1 req0 v0 pc=00000104",
                         addr_err, imem_req, instr_valid, pc);
            end
            @(negedge clk);
        end
`else
        consume(1, 1, 0, 0, 32'h0000_2002, 32'h0000_2000, 0);
        fetch_word(W_ADD, 0, waited);
        n_checks++;
        if (addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL addr_err_tied act=%b exp=0", addr_err);
        end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_valid act=v%b req%b e%b exp=v0 req0 e0", instr_valid, imem_req, addr_err);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = W_ORI;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_fetch act=req%b pc=%h v%b exp=req0 pc=0 v0", imem_req, pc, instr_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            n_err++;
            $display("FAIL restart act=req%b %h v%b i=%h exp=req1 0 v0 i=0", imem_req, imem_addr, instr_valid, instr);
        end
        exp_q.push_back(32'h0);
    endtask

    task automatic test_wrap();
        int waited;
        fetch_word(W_JR, 0, waited);
        consume(1, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
        fetch_word(W_ADD, 0, waited);
        n_checks++;
        if (pc_plus4 !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_plus4 act=%h exp=00000000", pc_plus4);
        end
        consume(0, 0, 0, 0, 32'h0, 32'h0, 0);
        fetch_word(W_LW, 0, waited);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_jump();
        test_branch();
        test_jr_misalign();
        test_reset_mid_fetch();
        test_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain act=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
